// File: rtl/fpga20_bus_support.sv
// Pin-side front end for the fpga20 Z80-bus peripheral: strobe/PHI synchronisers,
// PHI rising-edge pulse and two free-running LED blink counters.
module fpga20_bus_support #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT1_WIDTH  = 24,
  parameter int unsigned CNT2_WIDTH  = 22
) (
  input  logic CLK1,
  input  logic RST,
  input  logic PHI,
  input  logic IORQ,
  input  logic RD,
  input  logic WR,
  output logic io_read,
  output logic io_write,
  output logic phi_read,
  output logic phi_edge,
  output logic blink1,
  output logic blink2
);

  logic                   rd_req;
  logic                   wr_req;
  logic [SYNC_STAGES-1:0] rd_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] phi_sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   phi_prev;
  logic                   phi_armed;
  logic [CNT1_WIDTH-1:0]  cnt1;
  logic [CNT2_WIDTH-1:0]  cnt2;

  always_comb begin
    rd_req = ~IORQ & ~RD;
    wr_req = ~IORQ & ~WR;
  end

  // fill marks when phi_read carries a real PHI sample rather than the reset
  // value; the edge detector only arms after such a sample reads low, so a
  // PHI that is already high at reset release cannot produce a pulse.
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      rd_sync   <= '0;
      wr_sync   <= '0;
      phi_sync  <= '0;
      fill      <= '0;
      phi_prev  <= 1'b0;
      phi_armed <= 1'b0;
      cnt1      <= '0;
      cnt2      <= '0;
    end else begin
      rd_sync   <= {rd_sync[SYNC_STAGES-2:0], rd_req};
      wr_sync   <= {wr_sync[SYNC_STAGES-2:0], wr_req};
      phi_sync  <= {phi_sync[SYNC_STAGES-2:0], PHI};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      phi_prev  <= phi_read;
      phi_armed <= phi_armed | (fill[SYNC_STAGES-1] & ~phi_read);
      cnt1      <= cnt1 + 1'b1;
      if (phi_edge) cnt2 <= cnt2 + 1'b1;
    end
  end

  always_comb begin
    io_read  = rd_sync[SYNC_STAGES-1];
    io_write = wr_sync[SYNC_STAGES-1];
    phi_read = phi_sync[SYNC_STAGES-1];
    phi_edge = phi_read & ~phi_prev & phi_armed;
    blink1   = cnt1[CNT1_WIDTH-1];
    blink2   = cnt2[CNT2_WIDTH-1];
  end

endmodule

// File: tb/tb_fpga20_bus_support.sv
// Scoreboard bench for fpga20_bus_support: expected outputs are derived from the
// history of sampled inputs and pushed per clock edge; a monitor compares them.
module tb_fpga20_bus_support;

  localparam int S  = 2;
  localparam int W1 = 4;
  localparam int W2 = 3;

  logic CLK1, RST, PHI, IORQ, RD, WR;
  logic io_read, io_write, phi_read, phi_edge, blink1, blink2;

  fpga20_bus_support #(
    .SYNC_STAGES(S),
    .CNT1_WIDTH (W1),
    .CNT2_WIDTH (W2)
  ) dut (
    .CLK1    (CLK1),
    .RST     (RST),
    .PHI     (PHI),
    .IORQ    (IORQ),
    .RD      (RD),
    .WR      (WR),
    .io_read (io_read),
    .io_write(io_write),
    .phi_read(phi_read),
    .phi_edge(phi_edge),
    .blink1  (blink1),
    .blink2  (blink2)
  );

  initial CLK1 = 1'b0;
  always #5 CLK1 = ~CLK1;

  int edge_cnt = 0;
  always @(posedge CLK1) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         cyc;
    logic [5:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: edges since reset release, decoded input history, pulse count.
  int         n = 0;
  logic [2:0] h[$];
  int         nedges = 0;

  function automatic logic hist_bit(int k, int b);
    if (k >= S) return h[k-S+1][b];
    return 1'b0;
  endfunction

  task automatic model_step(input logic rst_i, phi_i, iorq_i, rd_i, wr_i,
                            output logic [5:0] e);
    logic pr_now, pe, b1, b2;
    if (rst_i) begin
      n = 0;
      h.delete();
      h.push_back(3'b000);
      nedges = 0;
      e = '0;
    end else begin
      n++;
      h.push_back({~iorq_i & ~rd_i, ~iorq_i & ~wr_i, phi_i});
      pr_now = hist_bit(n, 0);
      pe = pr_now && !hist_bit(n-1, 0) && (n-1 >= S);
      b1 = (n % (1 << W1)) >= (1 << (W1-1));
      b2 = (nedges % (1 << W2)) >= (1 << (W2-1));
      e = {hist_bit(n, 2), hist_bit(n, 1), pr_now, pe, b1, b2};
      if (pe) nedges++;
    end
  endtask

  task automatic cycle(input logic rst_i, phi_i, iorq_i, rd_i, wr_i);
    logic [5:0] e;
    exp_t item;
    @(negedge CLK1);
    RST = rst_i; PHI = phi_i; IORQ = iorq_i; RD = rd_i; WR = wr_i;
    model_step(rst_i, phi_i, iorq_i, rd_i, wr_i, e);
    item.cyc = edge_cnt + 1;
    item.exp = e;
    sb.push_back(item);
  endtask

  // Monitor: one comparison per expected edge.
  initial begin
    exp_t item;
    logic [5:0] got;
    forever begin
      @(posedge CLK1);
      #1;
      got = {io_read, io_write, phi_read, phi_edge, blink1, blink2};
      while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
        item = sb.pop_front();
        checks++;
        if (item.cyc != edge_cnt || got != item.exp) begin
          errors++;
          $display("FAIL outputs cyc=%0d (exp for %0d) got=%b exp=%b [rd wr phi edge b1 b2]",
                   edge_cnt, item.cyc, got, item.exp);
        end
      end
    end
  end

  logic phi_lvl = 1'b0;
  int   phi_left = 0;

  function automatic logic next_phi();
    if (phi_left == 0) begin
      phi_lvl  = ~phi_lvl;
      phi_left = $urandom_range(2, 5);
    end
    phi_left--;
    return phi_lvl;
  endfunction

  task automatic rand_cycle();
    logic p;
    p = next_phi();
    cycle(1'b0, p, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    RST = 1'b1; PHI = 1'b0; IORQ = 1'b0; RD = 1'b0; WR = 1'b0;

    // Reset held with strobes active and PHI toggling: everything stays 0.
    for (int i = 0; i < 6; i++) cycle(1'b1, i[0], 1'b0, 1'b0, 1'b0);
    // Release with PHI already high: strobes track after S edges, no phi_edge.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Strobe latency and IORQ gating.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // PHI at CLK1/4 for ten periods.
    for (int p = 0; p < 10; p++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    end

    // Long random run covers blink rises/falls and counter wrap.
    for (int i = 0; i < 150; i++) rand_cycle();

    // Mid-operation asynchronous reset while blink1 is high.
    guard = 0;
    do begin
      rand_cycle();
      guard++;
    end while ((n % (1 << W1)) < (1 << (W1-1)) && guard < 40);
    @(negedge CLK1);
    #2 RST = 1'b1;
    #1;
    checks++;
    if (guard >= 40 || {io_read, io_write, phi_read, phi_edge, blink1, blink2} != 6'b0) begin
      errors++;
      $display("FAIL async_reset got=%b exp=000000 guard=%0d",
               {io_read, io_write, phi_read, phi_edge, blink1, blink2}, guard);
    end
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) rand_cycle();

    @(posedge CLK1);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
